// File: rtl/ervp_register_file_stream_reader.sv
// Read-side sequencer for a 1R1W synchronous-read register file. It walks a wrap-around
// index range and streams the returned words over valid/ready with a last-beat marker.
module ervp_register_file_stream_reader #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BW_INDEX = 4,
    parameter int unsigned BW_COUNT = BW_INDEX + 1
) (
    input  logic                clk,
    input  logic                rstp,
    input  logic                start,
    input  logic [BW_INDEX-1:0] start_index,
    input  logic [BW_COUNT-1:0] num_entries,
    output logic                busy,
    output logic                done,
    output logic [BW_INDEX-1:0] rf_rindex,
    output logic                rf_renable,
    input  logic [WIDTH-1:0]    rf_rdata_synch,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [WIDTH-1:0]    tx_data,
    output logic                tx_last
);
    localparam logic [BW_INDEX-1:0] LAST_INDEX = BW_INDEX'(DEPTH - 1);
    localparam logic [BW_COUNT-1:0] MAX_COUNT  = BW_COUNT'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state;
    state_t              next_state;

    logic [BW_INDEX-1:0] ptr;
    logic [BW_INDEX-1:0] rindex_hold;
    logic [BW_COUNT-1:0] num_q;
    logic [BW_COUNT-1:0] issued;
    logic                inflight;
    logic                inflight_last;

    logic                head_valid;
    logic                head_last;
    logic [WIDTH-1:0]    head_data;
    logic                tail_valid;
    logic                tail_last;
    logic [WIDTH-1:0]    tail_data;

    logic                pop_c;
    logic                push_c;
    logic                room_c;
    logic                accept_c;
    logic                issue_c;
    logic [1:0]          load_c;
    logic [BW_COUNT-1:0] num_eff_c;
    logic [BW_INDEX-1:0] index_eff_c;

    // Words held plus the word still coming back from the file, net of this cycle's pop
    assign pop_c  = head_valid & tx_ready;
    assign push_c = inflight;
    assign load_c = 2'(head_valid) + 2'(tail_valid) + 2'(inflight) - 2'(pop_c);
    assign room_c = (load_c < 2'd2);

    assign num_eff_c   = (num_entries > MAX_COUNT) ? MAX_COUNT : num_entries;
    assign index_eff_c = (32'(start_index) >= DEPTH) ? '0 : start_index;

    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        issue_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    next_state = (num_entries == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (room_c && (issued != num_q)) begin
                    issue_c = 1'b1;
                    if ((issued + BW_COUNT'(1)) == num_q) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && head_last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == READ) || (next_state == DRAIN);
            done  <= (next_state == DONE);
        end
    end

    // Command capture, read pointer and in-flight tracking
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            ptr           <= '0;
            rindex_hold   <= '0;
            num_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                inflight_last <= ((issued + BW_COUNT'(1)) == num_q);
            end
            if (accept_c) begin
                ptr    <= index_eff_c;
                num_q  <= num_eff_c;
                issued <= '0;
            end else if (issue_c) begin
                ptr         <= (ptr == LAST_INDEX) ? '0 : ptr + BW_INDEX'(1);
                rindex_hold <= ptr;
                issued      <= issued + BW_COUNT'(1);
            end
        end
    end

    assign rf_renable = issue_c;
    assign rf_rindex  = issue_c ? ptr : rindex_hold;

    // Two-entry output FIFO built as head/tail registers so the stream is driven by flops
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
            tail_data  <= '0;
        end else begin
            case ({push_c, pop_c})
                2'b01: begin
                    head_valid <= tail_valid;
                    head_last  <= tail_valid & tail_last;
                    if (tail_valid) begin
                        head_data <= tail_data;
                    end
                    tail_valid <= 1'b0;
                    tail_last  <= 1'b0;
                end
                2'b10: begin
                    if (head_valid) begin
                        tail_valid <= 1'b1;
                        tail_data  <= rf_rdata_synch;
                        tail_last  <= inflight_last;
                    end else begin
                        head_valid <= 1'b1;
                        head_data  <= rf_rdata_synch;
                        head_last  <= inflight_last;
                    end
                end
                2'b11: begin
                    if (tail_valid) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= rf_rdata_synch;
                        tail_last <= inflight_last;
                    end else begin
                        head_data <= rf_rdata_synch;
                        head_last <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_valid = head_valid;
    assign tx_data  = head_data;
    assign tx_last  = head_last;

endmodule

// File: tb/tb_ervp_register_file_stream_reader.sv
// Bench for ervp_register_file_stream_reader: a DEPTH=16 and a DEPTH=12 instance, each
// backed by a synchronous-read file model, checked against a beat/index scoreboard.
`timescale 1ns/1ps
module tb_ervp_register_file_stream_reader;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned BW_INDEX = 4;
    localparam int unsigned BW_COUNT = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rstp = 1'b0;
    logic                tx_ready = 1'b0;
    logic [1:0]          start_v = '0;
    logic [BW_INDEX-1:0] sidx_v [2];
    logic [BW_COUNT-1:0] num_v [2];
    int                  sel = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned      D    = (g == 0) ? 16 : 12;
        localparam logic [WIDTH-1:0] BASE = (g == 0) ? 32'h100 : 32'h200;
        logic                busy, done, rf_renable, tx_valid, tx_last;
        logic [BW_INDEX-1:0] rf_rindex;
        logic [WIDTH-1:0]    tx_data;
        logic [WIDTH-1:0]    rf_rdata = '0;

        // File model: entry k holds BASE+k, returned the cycle after the strobe and held
        always @(posedge clk) if (rf_renable) rf_rdata <= BASE + WIDTH'(rf_rindex);

        ervp_register_file_stream_reader #(
            .DEPTH(D), .WIDTH(WIDTH), .BW_INDEX(BW_INDEX), .BW_COUNT(BW_COUNT)
        ) u_dut (
            .clk(clk), .rstp(rstp), .start(start_v[g]), .start_index(sidx_v[g]),
            .num_entries(num_v[g]), .busy(busy), .done(done), .rf_rindex(rf_rindex),
            .rf_renable(rf_renable), .rf_rdata_synch(rf_rdata), .tx_valid(tx_valid),
            .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last)
        );
    end

    logic                a_busy, a_done, a_ren, a_valid, a_last;
    logic [BW_INDEX-1:0] a_idx;
    logic [WIDTH-1:0]    a_data;
    assign a_busy  = (sel == 1) ? g_dut[1].busy       : g_dut[0].busy;
    assign a_done  = (sel == 1) ? g_dut[1].done       : g_dut[0].done;
    assign a_ren   = (sel == 1) ? g_dut[1].rf_renable : g_dut[0].rf_renable;
    assign a_idx   = (sel == 1) ? g_dut[1].rf_rindex  : g_dut[0].rf_rindex;
    assign a_valid = (sel == 1) ? g_dut[1].tx_valid   : g_dut[0].tx_valid;
    assign a_last  = (sel == 1) ? g_dut[1].tx_last    : g_dut[0].tx_last;
    assign a_data  = (sel == 1) ? g_dut[1].tx_data    : g_dut[0].tx_data;

    beat_t exp_q[$];
    int    idx_q[$];
    int    n_pass = 0;
    int    n_chk  = 0;
    int    cyc    = 0;
    int    issued_n = 0, popped_n = 0, done_n = 0, done_cyc = 0, rise_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, between the driving edges
    always @(negedge clk) begin : mon
        beat_t               b;
        beat_t               prev_beat;
        logic                prev_stall;
        logic                prev_valid;
        logic [BW_INDEX-1:0] last_idx;
        if (rstp) begin
            exp_q.delete();
            idx_q.delete();
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            issued_n   = 0;
            popped_n   = 0;
            last_idx   = '0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(a_valid), 64'(1));
                check("stall_data", 64'(a_data), 64'(prev_beat.data));
                check("stall_last", 64'(a_last), 64'(prev_beat.last));
            end
            if (!a_valid) check("last_without_valid", 64'(a_last), 64'(0));
            if (a_valid && tx_ready) begin
                popped_n++;
                if (exp_q.size() == 0) check("unexpected_beat", 64'(1), 64'(0));
                else begin
                    b = exp_q.pop_front();
                    check("tx_data", 64'(a_data), 64'(b.data));
                    check("tx_last", 64'(a_last), 64'(b.last));
                end
            end
            if (a_ren) begin
                issued_n++;
                if (idx_q.size() == 0) check("unexpected_read", 64'(1), 64'(0));
                else check("rf_rindex", 64'(a_idx), 64'(idx_q.pop_front()));
                check("outstanding_le_2", 64'((issued_n - popped_n) <= 2), 64'(1));
                last_idx = a_idx;
            end else if (a_busy) begin
                check("rindex_hold", 64'(a_idx), 64'(last_idx));
            end
            if (a_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (a_valid && !prev_valid) rise_cyc = cyc;
            prev_valid     = a_valid;
            prev_stall     = a_valid && !tx_ready;
            prev_beat.data = a_data;
            prev_beat.last = a_last;
        end
    end

    // Push the expected stream, issue one command and wait (bounded) for done
    task automatic run_cmd(input int s, input int idx, input int n, input bit bp,
                           input bit poke, input bit timed);
        int    d;
        int    base;
        int    ne;
        int    se;
        int    start_cyc;
        int    base_done;
        bit    got;
        beat_t b;
        d    = (s == 0) ? 16 : 12;
        base = (s == 0) ? 'h100 : 'h200;
        ne   = (n > d) ? d : n;
        se   = (idx >= d) ? 0 : idx;
        sel  = s;
        for (int i = 0; i < ne; i++) begin
            int e;
            e = (se + i) % d;
            idx_q.push_back(e);
            b.data = WIDTH'(base + e);
            b.last = (i == ne - 1);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        base_done   = done_n;
        start_v[s]  = 1'b1;
        sidx_v[s]   = BW_INDEX'(idx);
        num_v[s]    = BW_COUNT'(n);
        tx_ready    = 1'b1;
        start_cyc   = cyc;
        got         = 1'b0;
        for (int k = 1; k <= 400 && !got; k++) begin
            @(posedge clk); #1;
            start_v[s] = poke && (k == 3);
            if (poke && (k == 3)) begin
                sidx_v[s] = BW_INDEX'(1);
                num_v[s]  = BW_COUNT'(3);
            end
            if (k == 1) check("busy_after_start", 64'(a_busy), 64'(ne > 0));
            tx_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (done_n > base_done) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'(0), 64'(1));
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_n - base_done), 64'(1));
        check("beats_left", 64'(exp_q.size()), 64'(0));
        check("reads_left", 64'(idx_q.size()), 64'(0));
        check("busy_idle", 64'(a_busy), 64'(0));
        if (timed) begin
            check("done_cycle", 64'(done_cyc - start_cyc), 64'((ne == 0) ? 1 : ne + 3));
            if (ne > 0) check("first_valid_cycle", 64'(rise_cyc - start_cyc), 64'(3));
        end
    endtask

    task automatic check_reset_outputs(input int s, input string tag);
        logic [WIDTH+BW_INDEX+5:0] v;
        if (s == 0) v = {g_dut[0].busy, g_dut[0].done, g_dut[0].rf_renable, g_dut[0].rf_rindex,
                         g_dut[0].tx_valid, g_dut[0].tx_data, g_dut[0].tx_last};
        else        v = {g_dut[1].busy, g_dut[1].done, g_dut[1].rf_renable, g_dut[1].rf_rindex,
                         g_dut[1].tx_valid, g_dut[1].tx_data, g_dut[1].tx_last};
        check(tag, 64'(v), 64'(0));
    endtask

    initial begin
        sidx_v[0] = '0; sidx_v[1] = '0;
        num_v[0]  = '0; num_v[1]  = '0;
        #1 rstp = 1'b1;
        #1;
        check_reset_outputs(0, "reset_outputs_d16");
        check_reset_outputs(1, "reset_outputs_d12");
        repeat (2) @(posedge clk);
        #1 rstp = 1'b0;

        run_cmd(0, 3, 4, 1'b0, 1'b0, 1'b1);    // basic run
        run_cmd(1, 10, 4, 1'b0, 1'b0, 1'b1);   // wrap at DEPTH=12
        run_cmd(0, 6, 8, 1'b1, 1'b1, 1'b0);    // back-pressure, start poked while busy
        run_cmd(0, 2, 0, 1'b0, 1'b0, 1'b1);    // zero-length
        run_cmd(0, 9, 20, 1'b0, 1'b0, 1'b1);   // clamped to 16 beats
        run_cmd(1, 14, 3, 1'b0, 1'b0, 1'b1);   // out-of-range start index

        // Reset during the second beat of an 8-beat command
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            idx_q.push_back(i);
            b.data = WIDTH'(32'h100 + i);
            b.last = (i == 7);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        sidx_v[0]  = '0;
        num_v[0]   = BW_COUNT'(8);
        tx_ready   = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstp = 1'b1;
        #1;
        check_reset_outputs(0, "mid_command_reset");
        repeat (2) @(posedge clk);
        #1 rstp = 1'b0;
        run_cmd(0, 5, 2, 1'b0, 1'b0, 1'b1);    // fresh command after reset

        run_cmd(1, 7, 12, 1'b1, 1'b0, 1'b0);   // full wrap under back-pressure

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ervp_register_file_stream_reader.md
# ervp_register_file_stream_reader

Sequencing read-side master for a synchronous-read register file in the 1R1W style. On a start command it walks a contiguous, wrap-around index range, issues one read per entry through the file's `rindex`/`renable`/`rdata_synch` port, and presents the returned words as a valid/ready stream with a last-beat marker. It sits between a register file and a streaming consumer such as a DMA or serializer, and drains the file without stalling the consumer.

## Interface
Parameters:
- `DEPTH`, 16: number of register-file entries; index wrap point.
- `WIDTH`, 32: data word width.
- `BW_INDEX`, 4: index width; must satisfy 2^BW_INDEX >= DEPTH.
- `BW_COUNT`, BW_INDEX+1: width of the entry-count input.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rstp`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `start_index`, in, BW_INDEX: first entry to read.
- `num_entries`, in, BW_COUNT: number of entries to stream.
- `busy`, out, 1: high from the cycle after an accepted start until the cycle `done` is asserted.
- `done`, out, 1: one-cycle completion pulse.
- `rf_rindex`, out, BW_INDEX: read index to the register file.
- `rf_renable`, out, 1: read strobe. The file returns `rf_rdata_synch` one cycle later and holds it until the next strobe.
- `rf_rdata_synch`, in, WIDTH: registered read data from the file.
- `tx_valid`, out, 1: stream beat valid.
- `tx_ready`, in, 1: stream consumer ready.
- `tx_data`, out, WIDTH: stream data.
- `tx_last`, out, 1: marks the final beat of a command.

## Operation
- **States:** IDLE, READ, DRAIN, DONE.
- **IDLE:**
  - `start`=1 with `num_entries`>0 goes to READ.
  - `start`=1 with `num_entries`=0 goes to DONE.
  - `start` is ignored in every other state.
- **Command capture on accept:**
  - `num_entries` > DEPTH is clamped to DEPTH.
  - `start_index` >= DEPTH is replaced by 0.
  - The read pointer loads the effective start index; the issued and sent counters clear.
- **READ:**
  - Asserts `rf_renable` with `rf_rindex` = pointer only when (buffer occupancy + reads in flight − pop this cycle) < 2. A pop is `tx_valid & tx_ready`.
  - The pointer increments modulo DEPTH: DEPTH−1 wraps to 0, never to 2^BW_INDEX−1.
  - Goes to DRAIN in the cycle after the read that brings the issued count to `num_entries`.
- **Capture:** the cycle after each `rf_renable`, `rf_rdata_synch` is written into a 2-entry output FIFO. Each entry carries a last flag, set when the sent-count of that read equals `num_entries`−1.
- **DRAIN:** no reads; goes to DONE on the handshake of the beat with `tx_last`=1.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE. A `start` in the DONE cycle is ignored.
- **Stream rules:**
  - `tx_valid` = FIFO non-empty; `tx_data`/`tx_last` come from the FIFO head.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_last` and `tx_valid` are held stable.
  - `tx_last` is never asserted with `tx_valid`=0.
- **Flow control:** the FIFO never overflows. In-flight accounting guarantees space for every returned word, because the file gives no back-pressure.
- **Reset** (any time, including mid-command): the FSM goes to IDLE and the FIFO, counters, pointer and in-flight flag clear. A read in flight is discarded.
- **Reset values:** `busy`=0, `done`=0, `rf_renable`=0, `rf_rindex`=0, `tx_valid`=0, `tx_data`=0, `tx_last`=0.
- `rf_rindex` holds its last value when `rf_renable`=0.

## Timing
- Cycle 0: `start` high, sampled at the end of the cycle.
- Cycle 1: `busy`=1, first `rf_renable`.
- Cycle 2: FIFO write.
- Cycle 3: first `tx_valid`.
- With `tx_ready` held 1: one beat per cycle from cycle 3, the last beat in cycle 2+N, and `done` in cycle 3+N.
- Zero-length command: `done` in cycle 1, with no `rf_renable` and no `tx_valid`.
- After `tx_ready` deasserts, at most 2 further reads are issued before reads stop.
- Reads resume in the same cycle as the first subsequent pop.
- No combinational path from `tx_ready` to `tx_valid` or `tx_data`. A combinational path from `tx_ready` to `rf_renable` is permitted.

## Test plan
- **Basic run:** DEPTH=16; preload entry k with 0x100+k; start with `start_index`=3, N=4, `tx_ready`=1 → beats 0x103, 0x104, 0x105, 0x106 in cycles 3–6, `tx_last` only on 0x106, `done` in cycle 7.
- **Wrap-around:** DEPTH=12, 2^BW_INDEX=16; `start_index`=10, N=4 → `rf_rindex` sequence 10, 11, 0, 1; data matches those entries.
- **Back-pressure:** N=8 with `tx_ready` toggling 1,0,0,1 repeatedly → all 8 words delivered in order with no loss or duplicate, `tx_data` stable during stalls, at most 2 reads outstanding beyond the head.
- **Edge commands:**
  - N=0 → single `done`, no reads.
  - N=20 with DEPTH=16 → exactly 16 beats.
  - `start` pulsed while `busy` → ignored, stream unchanged.
- **Reset mid-command:** assert `rstp` during beat 2 of N=8 → all outputs return to reset values asynchronously. After release, a new command N=2 streams correctly with no stale data.
